// File: rtl/branch_predict_unit_pkg.sv
// Shared types and constants for the branch prediction unit: RISC-V control
// opcodes, branch condition codes, BTB entry layout and BHT reset state.
package bpu_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  // Tag is kept full width; the unused upper bits are always zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic        is_jump;
  } btb_entry_t;

  localparam logic [1:0] BHT_RESET = 2'b01;

  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'b11) ? cnt : cnt + 2'd1;
    end else begin
      res = (cnt == 2'b00) ? cnt : cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predict_unit_resolve.sv
// Combinational EX-stage evaluation of JAL/JALR/B-type outcome and target.
module bpu_resolve
  import bpu_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] ra,
  input  logic [31:0] rb,
  output logic        is_ctl,
  output logic        jump,
  output logic        taken,
  output logic [31:0] target
);

  logic [31:0] jalr_sum_s;
  assign jalr_sum_s = ra + imm;

  // Decode the instruction class and evaluate the branch condition.
  always_comb begin
    is_ctl = 1'b0;
    jump   = 1'b0;
    taken  = 1'b0;
    target = 32'd0;
    if (opcode == OPC_JAL) begin
      is_ctl = 1'b1;
      jump   = 1'b1;
      taken  = 1'b1;
      target = pc + imm;
    end else if (opcode == OPC_JALR) begin
      is_ctl = 1'b1;
      jump   = 1'b1;
      taken  = 1'b1;
      target = {jalr_sum_s[31:1], 1'b0};
    end else if (opcode == OPC_BRANCH) begin
      is_ctl = 1'b1;
      target = pc + imm;
      case (funct3_e'(funct3))
        F3_BEQ:  taken = (ra == rb);
        F3_BNE:  taken = (ra != rb);
        F3_BLT:  taken = ($signed(ra) <  $signed(rb));
        F3_BGE:  taken = ($signed(ra) >= $signed(rb));
        F3_BLTU: taken = (ra <  rb);
        F3_BGEU: taken = (ra >= rb);
        default: begin
          is_ctl = 1'b0;
          target = 32'd0;
        end
      endcase
    end else begin
      is_ctl = 1'b0;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// IF-stage BTB/BHT prediction with EX-stage resolution, mispredict redirect,
// registered flush and wrapping performance counters.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             irq_flush_i,
  input  logic [31:0]      if_pc_i,
  output logic             pred_taken_o,
  output logic [31:0]      pred_target_o,
  input  logic             ex_valid_i,
  input  logic [6:0]       ex_opcode_i,
  input  logic [2:0]       ex_funct3_i,
  input  logic [31:0]      ex_pc_i,
  input  logic [31:0]      ex_imm_i,
  input  logic [31:0]      ex_ra_i,
  input  logic [31:0]      ex_rb_i,
  input  logic             ex_pred_taken_i,
  input  logic [31:0]      ex_pred_target_i,
  input  logic             hd_stall_i,
  output logic             ex_jump_o,
  output logic             ex_taken_o,
  output logic [31:0]      ex_target_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

  btb_entry_t       btb_r [BTB_ENTRIES];
  logic [1:0]       bht_r [BHT_ENTRIES];
  logic             flush_r;
  logic [CNT_W-1:0] br_cnt_r;
  logic [CNT_W-1:0] miss_cnt_r;

  logic [BTB_IDX_W-1:0] if_btb_idx_s, ex_btb_idx_s;
  logic [BHT_IDX_W-1:0] if_bht_idx_s, ex_bht_idx_s;
  logic [31:0]          if_tag_s, ex_tag_s;
  btb_entry_t           if_entry_s;
  logic                 if_hit_s;

  logic        is_ctl_s, ctl_s, mis_s, update_s;
  logic [31:0] ex_pc_plus4_s;

  assign if_btb_idx_s = if_pc_i[BTB_IDX_W+1:2];
  assign if_bht_idx_s = if_pc_i[BHT_IDX_W+1:2];
  assign if_tag_s     = if_pc_i >> (BTB_IDX_W + 2);
  assign ex_btb_idx_s = ex_pc_i[BTB_IDX_W+1:2];
  assign ex_bht_idx_s = ex_pc_i[BHT_IDX_W+1:2];
  assign ex_tag_s     = ex_pc_i >> (BTB_IDX_W + 2);

  assign if_entry_s    = btb_r[if_btb_idx_s];
  assign if_hit_s      = if_entry_s.valid & (if_entry_s.tag == if_tag_s);
  assign pred_taken_o  = if_hit_s & (if_entry_s.is_jump | bht_r[if_bht_idx_s][1]);
  assign pred_target_o = if_hit_s ? if_entry_s.target : (if_pc_i + 32'd4);

  bpu_resolve u_resolve (
    .opcode (ex_opcode_i),
    .funct3 (ex_funct3_i),
    .pc     (ex_pc_i),
    .imm    (ex_imm_i),
    .ra     (ex_ra_i),
    .rb     (ex_rb_i),
    .is_ctl (is_ctl_s),
    .jump   (ex_jump_o),
    .taken  (ex_taken_o),
    .target (ex_target_o)
  );

  assign ctl_s         = ex_valid_i & is_ctl_s;
  assign mis_s         = ctl_s & ((ex_taken_o != ex_pred_taken_i) |
                                  (ex_taken_o & (ex_target_o != ex_pred_target_i)));
  assign redirect_o    = mis_s & ~hd_stall_i;
  assign ex_pc_plus4_s = ex_pc_i + 32'd4;
  assign redirect_pc_o = ex_taken_o ? ex_target_o : ex_pc_plus4_s;
  assign update_s      = ctl_s & ~stall_i & ~hd_stall_i;

  // Table training, performance counters and flush register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_r[i] <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_r[i] <= BHT_RESET;
      br_cnt_r   <= '0;
      miss_cnt_r <= '0;
      flush_r    <= 1'b0;
    end else begin
      if (update_s) begin
        if (!ex_jump_o) begin
          bht_r[ex_bht_idx_s] <= bht_next(bht_r[ex_bht_idx_s], ex_taken_o);
        end
        if (ex_taken_o) begin
          btb_r[ex_btb_idx_s] <= '{valid: 1'b1, tag: ex_tag_s,
                                   target: ex_target_o, is_jump: ex_jump_o};
        end
        br_cnt_r <= br_cnt_r + CNT_W'(1);
        if (mis_s) begin
          miss_cnt_r <= miss_cnt_r + CNT_W'(1);
        end
      end
      if (!stall_i) begin
        flush_r <= irq_flush_i | redirect_o;
      end
    end
  end

  assign flush_o    = flush_r;
  assign br_cnt_o   = br_cnt_r;
  assign miss_cnt_o = miss_cnt_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit with hand-computed expectations.
module tb_branch_predict_unit;

  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BR   = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst, stall_i, irq_flush_i, hd_stall_i;
  logic [31:0] if_pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i, ex_pred_taken_i;
  logic [6:0]  ex_opcode_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_pc_i, ex_imm_i, ex_ra_i, ex_rb_i, ex_pred_target_i;
  logic        ex_jump_o, ex_taken_o, redirect_o, flush_o;
  logic [31:0] ex_target_o, redirect_pc_o, br_cnt_o, miss_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .irq_flush_i(irq_flush_i),
    .if_pc_i(if_pc_i), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .ex_valid_i(ex_valid_i), .ex_opcode_i(ex_opcode_i), .ex_funct3_i(ex_funct3_i),
    .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i), .ex_ra_i(ex_ra_i), .ex_rb_i(ex_rb_i),
    .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
    .hd_stall_i(hd_stall_i), .ex_jump_o(ex_jump_o), .ex_taken_o(ex_taken_o),
    .ex_target_o(ex_target_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .flush_o(flush_o), .br_cnt_o(br_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] ra, input logic [31:0] rb,
                        input logic pt, input logic [31:0] ptgt);
    ex_valid_i = v; ex_opcode_i = opc; ex_funct3_i = f3; ex_pc_i = pc;
    ex_imm_i = imm; ex_ra_i = ra; ex_rb_i = rb;
    ex_pred_taken_i = pt; ex_pred_target_i = ptgt;
    #1;
  endtask

  task automatic idle();
    set_ex(1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; irq_flush_i = 1'b0; hd_stall_i = 1'b0;
    if_pc_i = 32'h100;
    set_ex(1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_pred_taken", {31'd0, pred_taken_o}, 32'd0);
    chk("rst_pred_target", pred_target_o, 32'h104);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_br_cnt", br_cnt_o, 32'd0);
    chk("rst_miss_cnt", miss_cnt_o, 32'd0);

    // BEQ taken, predicted not-taken
    set_ex(1'b1, BR, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'd0);
    chk("beq_taken", {31'd0, ex_taken_o}, 32'd1);
    chk("beq_jump", {31'd0, ex_jump_o}, 32'd0);
    chk("beq_redirect", {31'd0, redirect_o}, 32'd1);
    chk("beq_redirect_pc", redirect_pc_o, 32'h120);
    chk("beq_same_cycle_lookup", {31'd0, pred_taken_o}, 32'd0);
    tick();
    chk("beq_flush", {31'd0, flush_o}, 32'd1);
    chk("beq_miss_cnt", miss_cnt_o, 32'd1);
    chk("beq_br_cnt", br_cnt_o, 32'd1);
    tick(); tick();
    chk("beq3_miss_cnt", miss_cnt_o, 32'd3);
    idle();
    chk("idle_flush_clear", {31'd0, flush_o}, 32'd0);
    chk("trained_pred_taken", {31'd0, pred_taken_o}, 32'd1);
    chk("trained_pred_target", pred_target_o, 32'h120);

    // Correctly predicted BEQ
    set_ex(1'b1, BR, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120);
    chk("beq_ok_redirect", {31'd0, redirect_o}, 32'd0);
    tick();
    chk("beq_ok_flush", {31'd0, flush_o}, 32'd0);
    chk("beq_ok_br_cnt", br_cnt_o, 32'd4);
    chk("beq_ok_miss_cnt", miss_cnt_o, 32'd3);

    // JALR at 0x200 aliases BTB index 0 with a different tag
    set_ex(1'b1, JALR, 3'b000, 32'h200, 32'd4, 32'h2003, 32'd0, 1'b0, 32'd0);
    chk("jalr_target", ex_target_o, 32'h2006);
    chk("jalr_jump", {31'd0, ex_jump_o}, 32'd1);
    chk("jalr_redirect", {31'd0, redirect_o}, 32'd1);
    tick();
    idle();
    if_pc_i = 32'h200; #1;
    chk("jalr_btb_taken", {31'd0, pred_taken_o}, 32'd1);
    chk("jalr_btb_target", pred_target_o, 32'h2006);
    if_pc_i = 32'h100; #1;
    chk("alias_evicted_taken", {31'd0, pred_taken_o}, 32'd0);
    chk("alias_evicted_target", pred_target_o, 32'h104);
    set_ex(1'b1, JALR, 3'b000, 32'h200, 32'd4, 32'h2003, 32'd0, 1'b1, 32'h2006);
    chk("jalr_ok_redirect", {31'd0, redirect_o}, 32'd0);
    tick();
    chk("jalr_ok_counts", {br_cnt_o[15:0], miss_cnt_o[15:0]}, {16'd6, 16'd4});

    // JAL
    set_ex(1'b1, JAL, 3'b000, 32'h400, 32'hFFFF_FFF0, 32'd0, 32'd0, 1'b1, 32'h3F0);
    chk("jal_target", ex_target_o, 32'h3F0);
    chk("jal_redirect", {31'd0, redirect_o}, 32'd0);
    tick();

    // Signed vs unsigned compare
    set_ex(1'b1, BR, 3'b100, 32'h300, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h310);
    chk("blt_taken", {31'd0, ex_taken_o}, 32'd1);
    chk("blt_redirect", {31'd0, redirect_o}, 32'd0);
    tick();
    set_ex(1'b1, BR, 3'b110, 32'h300, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
    chk("bltu_taken", {31'd0, ex_taken_o}, 32'd0);
    chk("bltu_redirect_pc", redirect_pc_o, 32'h304);
    tick();
    chk("bltu_br_cnt", br_cnt_o, 32'd9);

    // Illegal funct3 is not a control instruction
    set_ex(1'b1, BR, 3'b010, 32'h300, 32'h10, 32'd1, 32'd1, 1'b1, 32'h310);
    chk("f3_010_taken", {31'd0, ex_taken_o}, 32'd0);
    chk("f3_010_target", ex_target_o, 32'd0);
    chk("f3_010_redirect", {31'd0, redirect_o}, 32'd0);
    tick();
    chk("f3_010_br_cnt", br_cnt_o, 32'd9);

    // Global stall freezes flush and counters
    stall_i = 1'b1;
    set_ex(1'b1, BR, 3'b000, 32'h100, 32'h20, 32'd1, 32'd2, 1'b1, 32'h120);
    chk("stall_redirect", {31'd0, redirect_o}, 32'd1);
    chk("stall_redirect_pc", redirect_pc_o, 32'h104);
    tick();
    chk("stall_flush", {31'd0, flush_o}, 32'd0);
    chk("stall_counts", {br_cnt_o[15:0], miss_cnt_o[15:0]}, {16'd9, 16'd4});
    stall_i = 1'b0;

    // Hazard stall masks redirect
    hd_stall_i = 1'b1; #1;
    chk("hd_redirect", {31'd0, redirect_o}, 32'd0);
    tick();
    chk("hd_flush", {31'd0, flush_o}, 32'd0);
    chk("hd_br_cnt", br_cnt_o, 32'd9);
    hd_stall_i = 1'b0;

    // Interrupt flush pulse
    irq_flush_i = 1'b1;
    idle();
    chk("irq_flush", {31'd0, flush_o}, 32'd1);
    irq_flush_i = 1'b0;
    idle();
    chk("irq_flush_drop", {31'd0, flush_o}, 32'd0);

    // Interrupt together with mispredict still updates counters
    irq_flush_i = 1'b1;
    set_ex(1'b1, BR, 3'b001, 32'h100, 32'h20, 32'd1, 32'd2, 1'b0, 32'd0);
    tick();
    irq_flush_i = 1'b0;
    chk("irq_mis_flush", {31'd0, flush_o}, 32'd1);
    chk("irq_mis_counts", {br_cnt_o[15:0], miss_cnt_o[15:0]}, {16'd10, 16'd5});

    // Reset during a mispredict
    rst = 1'b1;
    set_ex(1'b1, BR, 3'b001, 32'h100, 32'h20, 32'd1, 32'd2, 1'b0, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    if_pc_i = 32'h200; #1;
    chk("rst_mid_counts", {br_cnt_o[15:0], miss_cnt_o[15:0]}, 32'd0);
    chk("rst_mid_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_mid_pred_taken", {31'd0, pred_taken_o}, 32'd0);
    chk("rst_mid_pred_target", pred_target_o, 32'h204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
